// File: rtl/mdio_pkg.sv
// ============================================================================
// Module  : mdio_pkg
// Purpose : Shared MDIO frame field codes, widths and controller state codes.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mdio_pkg;

  localparam logic [1:0] ST_CODE  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;

  localparam int FRAME_W = 32;
  localparam int DATA_W  = 16;
  localparam int TA_IDX  = 17;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_RECV  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Only ST=01 with a write or read opcode is a frame we can issue.
  function automatic logic frame_ok(input logic [FRAME_W-1:0] f);
    return (f[FRAME_W-1 -: 2] == ST_CODE) &&
           ((f[FRAME_W-3 -: 2] == OP_WRITE) || (f[FRAME_W-3 -: 2] == OP_READ));
  endfunction

endpackage

`default_nettype wire

// File: rtl/mdc_clkgen.sv
// ============================================================================
// Module  : mdc_clkgen
// Purpose : MDC divider; flags the CLK edges on which MDC will rise or fall.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mdc_clkgen #(
  parameter int CLK_DIV = 4
) (
  input  logic CLK,
  input  logic RESET,
  input  logic en,
  output logic mdc,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam int HALF  = CLK_DIV / 2;
  localparam int DIV_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [DIV_W-1:0] c_LAST = DIV_W'(HALF - 1);

  logic [DIV_W-1:0] r_div;
  logic             r_mdc;
  logic             w_wrap;

  assign w_wrap = en && (r_div == c_LAST);

  // Held at zero while disabled so the first rise lands HALF cycles after enable.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_div <= '0;
      r_mdc <= 1'b0;
    end else if (!en) begin
      r_div <= '0;
      r_mdc <= 1'b0;
    end else if (w_wrap) begin
      r_div <= '0;
      r_mdc <= ~r_mdc;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  assign mdc        = r_mdc;
  assign rise_pulse = w_wrap & ~r_mdc;
  assign fall_pulse = w_wrap &  r_mdc;

endmodule

`default_nettype wire

// File: rtl/mdio_controller.sv
// ============================================================================
// Module  : mdio_controller
// Purpose : MDIO station-management master: serialises 32-bit frames, reads back PHY data.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mdio_controller
  import mdio_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               MDIO_START,
  input  logic [FRAME_W-1:0] T_DATA,
  input  logic               MDIO_IN,
  output logic               MDC,
  output logic               MDIO_OE,
  output logic               MDIO_OUT,
  output logic [DATA_W-1:0]  RD_DATA,
  output logic               DATA_RDY,
  output logic               XFER_DONE,
  output logic               BUSY,
  output logic               OP_ERR
);

  localparam logic [4:0] c_BIT_MSB  = 5'(FRAME_W - 1);
  localparam logic [4:0] c_TA_PREV  = 5'(TA_IDX + 1);
  localparam logic [4:0] c_DATA_MSB = 5'(DATA_W - 1);

  logic [1:0]         r_state;
  logic [FRAME_W-1:0] r_shift;
  logic               r_is_read;
  logic [4:0]         r_bit_cnt;
  logic [DATA_W-1:0]  r_rd_shift;
  logic [DATA_W-1:0]  r_rd_data;
  logic               r_oe;
  logic               r_data_rdy;
  logic               r_xfer_done;
  logic               r_busy;
  logic               r_op_err;

  logic w_en;
  logic w_mdc;
  logic w_rise;
  logic w_fall;

  assign w_en = (r_state == S_DRIVE) || (r_state == S_RECV);

  mdc_clkgen #(
    .CLK_DIV    (CLK_DIV)
  ) u_clkgen (
    .CLK        (CLK),
    .RESET      (RESET),
    .en         (w_en),
    .mdc        (w_mdc),
    .rise_pulse (w_rise),
    .fall_pulse (w_fall)
  );

  // MDIO_OUT is the shift-register MSB; clearing the register releases the line to 0.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_is_read   <= 1'b0;
      r_bit_cnt   <= c_BIT_MSB;
      r_rd_shift  <= '0;
      r_rd_data   <= '0;
      r_oe        <= 1'b0;
      r_data_rdy  <= 1'b0;
      r_xfer_done <= 1'b0;
      r_busy      <= 1'b0;
      r_op_err    <= 1'b0;
    end else begin
      r_data_rdy  <= 1'b0;
      r_xfer_done <= 1'b0;
      r_op_err    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (MDIO_START) begin
            if (!frame_ok(T_DATA)) begin
              r_op_err <= 1'b1;
            end else begin
              r_shift   <= T_DATA;
              r_is_read <= (T_DATA[FRAME_W-3 -: 2] == OP_READ);
              r_bit_cnt <= c_BIT_MSB;
              r_busy    <= 1'b1;
              r_oe      <= 1'b1;
              r_state   <= S_DRIVE;
            end
          end
        end
        S_DRIVE: begin
          if (w_fall) begin
            if (r_bit_cnt == 5'd0) begin
              r_oe        <= 1'b0;
              r_shift     <= '0;
              r_xfer_done <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_bit_cnt <= r_bit_cnt - 5'd1;
              // Reads hand the line to the PHY for the turnaround bits.
              if (r_is_read && (r_bit_cnt == c_TA_PREV)) begin
                r_oe    <= 1'b0;
                r_shift <= '0;
                r_state <= S_RECV;
              end else begin
                r_shift <= {r_shift[FRAME_W-2:0], 1'b0};
              end
            end
          end
        end
        S_RECV: begin
          if (w_rise && (r_bit_cnt <= c_DATA_MSB)) begin
            r_rd_shift <= {r_rd_shift[DATA_W-2:0], MDIO_IN};
          end
          if (w_fall) begin
            if (r_bit_cnt == 5'd0) begin
              r_rd_data   <= r_rd_shift;
              r_data_rdy  <= 1'b1;
              r_xfer_done <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_bit_cnt <= r_bit_cnt - 5'd1;
            end
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign MDC       = w_mdc;
  assign MDIO_OE   = r_oe;
  assign MDIO_OUT  = r_shift[FRAME_W-1];
  assign RD_DATA   = r_rd_data;
  assign DATA_RDY  = r_data_rdy;
  assign XFER_DONE = r_xfer_done;
  assign BUSY      = r_busy;
  assign OP_ERR    = r_op_err;

endmodule

`default_nettype wire

// File: tb/tb_mdio_controller.sv
// ============================================================================
// Module  : tb_mdio_controller
// Purpose : Scoreboard bench for mdio_controller at CLK_DIV = 4, 2 and 8.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mdio_controller;

  localparam int N = 3;

  typedef struct {
    int          inst;
    bit          is_err;
    bit          is_read;
    logic [31:0] frame;
    logic [15:0] exp_rd;
    logic [4:0]  exp_addr;
    logic [15:0] exp_wdata;
    int          issue;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic [N-1:0] start;
  logic [N-1:0] mdio_in;
  logic [N-1:0] mdc;
  logic [N-1:0] oe;
  logic [N-1:0] mout;
  logic [N-1:0] drdy;
  logic [N-1:0] xd;
  logic [N-1:0] busy;
  logic [N-1:0] operr;
  logic [31:0]  tdata  [N];
  logic [15:0]  rdd    [N];
  logic [15:0]  phy_rd [N];

  exp_t        sb[$];
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          rcnt     [N];
  logic [31:0] cap      [N];
  logic [31:0] capoe    [N];
  int          first_r  [N];
  int          last_r   [N];
  logic        prev_mdc [N];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < N; g++) begin : g_dut
    mdio_controller #(
      .CLK_DIV    ((g == 0) ? 4 : ((g == 1) ? 2 : 8))
    ) u_dut (
      .CLK        (clk),
      .RESET      (rst_n),
      .MDIO_START (start[g]),
      .T_DATA     (tdata[g]),
      .MDIO_IN    (mdio_in[g]),
      .MDC        (mdc[g]),
      .MDIO_OE    (oe[g]),
      .MDIO_OUT   (mout[g]),
      .RD_DATA    (rdd[g]),
      .DATA_RDY   (drdy[g]),
      .XFER_DONE  (xd[g]),
      .BUSY       (busy[g]),
      .OP_ERR     (operr[g])
    );
  end

  // Hand-computed per-divider timing: 1+32*DIV, 1+DIV/2, 31*DIV.
  function automatic int lat_of(input int i);
    case (i)
      0: return 129;
      1: return 65;
      default: return 257;
    endcase
  endfunction

  function automatic int first_of(input int i);
    case (i)
      0: return 3;
      1: return 2;
      default: return 5;
    endcase
  endfunction

  function automatic int span_of(input int i);
    case (i)
      0: return 124;
      1: return 62;
      default: return 248;
    endcase
  endfunction

  task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h expected %0h", name, inst, act, exp);
    end
  endtask

  // PHY model plus monitor; everything is sampled on the falling CLK edge.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      int   idx;
      exp_t e;
      if (!rst_n || !busy[i]) begin
        rcnt[i]    = 0;
        cap[i]     = '0;
        capoe[i]   = '0;
        mdio_in[i] = 1'b0;
      end else if (mdc[i] && !prev_mdc[i]) begin
        if (rcnt[i] < 32) begin
          cap[i][31-rcnt[i]]   = mout[i];
          capoe[i][31-rcnt[i]] = oe[i];
        end
        if (rcnt[i] == 0) first_r[i] = cyc;
        last_r[i] = cyc;
        rcnt[i]++;
      end else if (!mdc[i] && prev_mdc[i] && rcnt[i] >= 16 && rcnt[i] < 32) begin
        mdio_in[i] = phy_rd[i][31-rcnt[i]];
      end
      prev_mdc[i] = mdc[i];

      if (!rst_n) begin
        chk("reset_outputs", i, {mdc[i], oe[i], mout[i], drdy[i], xd[i], busy[i], operr[i], 9'd0, rdd[i]}, 32'h0);
        for (int k = sb.size() - 1; k >= 0; k--)
          if (sb[k].inst == i) sb.delete(k);
      end else if (xd[i] || operr[i]) begin
        idx = -1;
        foreach (sb[k]) if (idx < 0 && sb[k].inst == i) idx = k;
        if (idx < 0) begin
          chk("unexpected_event", i, {30'd0, xd[i], operr[i]}, 32'h0);
        end else begin
          e = sb[idx];
          sb.delete(idx);
          chk("event_kind", i, {31'd0, operr[i]}, {31'd0, e.is_err});
          if (e.is_err) begin
            chk("operr_latency", i, cyc - e.issue, 1);
            chk("operr_idle", i, {29'd0, busy[i], mdc[i], oe[i]}, 32'h0);
          end else begin
            chk("xfer_latency", i, cyc - e.issue, lat_of(i));
            chk("busy_at_done", i, {31'd0, busy[i]}, 32'h1);
            chk("rd_data", i, {16'd0, rdd[i]}, {16'd0, e.exp_rd});
            chk("data_rdy", i, {31'd0, drdy[i]}, {31'd0, e.is_read});
            chk("mdc_rises", i, rcnt[i], 32);
            chk("first_rise", i, first_r[i] - e.issue, first_of(i));
            chk("mdc_span", i, last_r[i] - first_r[i], span_of(i));
            if (e.is_read) begin
              chk("hdr_bits", i, {18'd0, cap[i][31:18]}, {18'd0, e.frame[31:18]});
              chk("oe_bits", i, capoe[i], 32'hFFFC0000);
            end else begin
              chk("frame_bits", i, cap[i], e.frame);
              chk("oe_bits", i, capoe[i], 32'hFFFFFFFF);
              chk("wr_addr", i, {27'd0, cap[i][22:18]}, {27'd0, e.exp_addr});
              chk("wr_data", i, {16'd0, cap[i][15:0]}, {16'd0, e.exp_wdata});
            end
          end
        end
      end else if (drdy[i]) begin
        chk("stray_data_rdy", i, 32'h1, 32'h0);
      end
    end
    for (int k = sb.size() - 1; k >= 0; k--) begin
      if (cyc > sb[k].issue + (sb[k].is_err ? 1 : lat_of(sb[k].inst)) + 8) begin
        chk("timeout", sb[k].inst, 32'h1, 32'h0);
        sb.delete(k);
      end
    end
  end

  task automatic issue(input int i, input logic [31:0] td, input bit err, input bit rd,
                       input logic [15:0] erd, input logic [4:0] ea, input logic [15:0] ew);
    exp_t e;
    @(negedge clk);
    tdata[i]    = td;
    start[i]    = 1'b1;
    e.inst      = i;
    e.is_err    = err;
    e.is_read   = rd;
    e.frame     = td;
    e.exp_rd    = erd;
    e.exp_addr  = ea;
    e.exp_wdata = ew;
    e.issue     = cyc;
    sb.push_back(e);
    @(negedge clk);
    start[i] = 1'b0;
  endtask

  task automatic pulse_start(input int i, input logic [31:0] td);
    @(negedge clk);
    tdata[i] = td;
    start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
  endtask

  task automatic wait_done(input int i);
    for (int t = 0; t < 3000; t++) begin
      bit pending;
      pending = 1'b0;
      foreach (sb[k]) if (sb[k].inst == i) pending = 1'b1;
      if (!pending) break;
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic b2b(input int i, input logic [15:0] rv);
    issue(i, 32'h5096ABCD, 1'b0, 1'b0, 16'h0000, 5'd5, 16'hABCD);
    for (int t = 0; t < 2000 && !xd[i]; t++) @(negedge clk);
    phy_rd[i] = rv;
    issue(i, 32'h60940000, 1'b0, 1'b1, rv, 5'd0, 16'h0000);
    wait_done(i);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    start = '0;
    for (int i = 0; i < N; i++) begin
      tdata[i]    = '0;
      phy_rd[i]   = '0;
      prev_mdc[i] = 1'b0;
      first_r[i]  = 0;
      last_r[i]   = 0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    issue(0, 32'h5096ABCD, 1'b0, 1'b0, 16'h0000, 5'd5, 16'hABCD);
    wait_done(0);

    phy_rd[0] = 16'h1234;
    issue(0, 32'h60940000, 1'b0, 1'b1, 16'h1234, 5'd0, 16'h0000);
    wait_done(0);

    issue(0, 32'h70000000, 1'b1, 1'b0, 16'h1234, 5'd0, 16'h0000);
    issue(0, 32'h40000000, 1'b1, 1'b0, 16'h1234, 5'd0, 16'h0000);
    wait_done(0);

    // Starts raised mid-frame must not disturb the write in flight.
    issue(0, 32'h5096ABCD, 1'b0, 1'b0, 16'h1234, 5'd5, 16'hABCD);
    repeat (8) @(negedge clk);
    pulse_start(0, 32'h60940000);
    repeat (48) @(negedge clk);
    pulse_start(0, 32'h70000000);
    wait_done(0);
    repeat (10) @(negedge clk);

    // Abort a read while bit 20 is on the wire, off the active edge.
    phy_rd[0] = 16'hBEEF;
    issue(0, 32'h60940000, 1'b0, 1'b1, 16'hBEEF, 5'd0, 16'h0000);
    repeat (45) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    issue(0, 32'h50A65A5A, 1'b0, 1'b0, 16'h0000, 5'd9, 16'h5A5A);
    wait_done(0);

    b2b(1, 16'hC3A5);
    b2b(2, 16'h8001);

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mdio_controller.md
Name: mdio_controller

Overview:
Station-management side of the MDIO link. It accepts a 32-bit management frame from the host and serialises it onto MDIO_OUT/MDIO_OE. It generates MDC from the system clock. For read frames it releases the bus and deserialises the PHY's MDIO_IN into RD_DATA. It drives the peripheral block's MDC/MDIO_OE/MDIO_OUT inputs directly and samples its MDIO_IN output.

Parameters:
CLK_DIV, 4, CLK cycles per MDC period; must be even and >=2. MDC high time and low time are each CLK_DIV/2.

Ports:
CLK  input  1  system clock; all logic runs on posedge CLK
RESET  input  1  asynchronous, active-low reset
MDIO_START  input  1  single-cycle request; sampled only in IDLE
T_DATA  input  32  frame: [31:30] ST=01, [29:28] OP (01 write, 10 read), [27:23] PHY addr, [22:18] REG addr, [17:16] TA, [15:0] write data
MDIO_IN  input  1  serial data from PHY
MDC  output  1  management clock
MDIO_OE  output  1  1 = controller drives MDIO_OUT
MDIO_OUT  output  1  serial data to PHY
RD_DATA  output  16  last read result; holds until next read completes
DATA_RDY  output  1  1-CLK pulse when RD_DATA is updated
XFER_DONE  output  1  1-CLK pulse at the end of any frame
BUSY  output  1  high from the accepted start until the DONE state exits
OP_ERR  output  1  1-CLK pulse when a start is rejected

Behaviour:
- Reset (RESET=0, asynchronous):
  - MDC, MDIO_OE, MDIO_OUT, DATA_RDY, XFER_DONE, BUSY, OP_ERR = 0; RD_DATA = 16'h0.
  - State = IDLE; divider counter = 0; bit_cnt = 31.
  - Reset asserted mid-frame aborts the frame immediately: no DONE pulse, RD_DATA keeps 0.
- States: IDLE, DRIVE, RECV, DONE.
- IDLE:
  - MDC held 0.
  - On MDIO_START=1:
    - If T_DATA[31:30]!=2'b01 or T_DATA[29:28] is 00 or 11: pulse OP_ERR, stay IDLE.
    - Otherwise, on the next edge: latch T_DATA into shift_reg, latch is_read = (OP==10), bit_cnt=31, BUSY=1, MDIO_OE=1, MDIO_OUT=T_DATA[31]; go to DRIVE.
  - MDIO_START while BUSY=1 is ignored (no error).
- MDC generation (DRIVE/RECV only):
  - Divider counts 0..CLK_DIV/2-1; MDC toggles on wrap.
  - The first rising edge of MDC occurs CLK_DIV/2 CLK cycles after entering DRIVE.
- Bit timing:
  - MDIO_OUT/MDIO_OE change only on the CLK edge that drives MDC 1->0, giving the PHY a full half-period of setup before the MDC rise.
  - On each MDC fall: bit_cnt decrements and MDIO_OUT takes the next shift_reg bit (MSB first).
- DRIVE:
  - Write: stays in DRIVE for all 32 bits (indices 31..0); MDIO_OE=1 throughout.
  - Read: on the MDC fall that moves bit_cnt to 17, MDIO_OE=0 and MDIO_OUT=0, and the state goes to RECV. TA bits 17:16 are not driven.
- RECV:
  - On the CLK edge that drives MDC 0->1 while bit_cnt is in 15..0: rd_shift = {rd_shift[14:0], MDIO_IN}.
- End of frame: the MDC fall after the bit-0 rise ends the frame.
  - MDC stays 0; MDIO_OE=0; MDIO_OUT=0; go to DONE.
- DONE (1 CLK):
  - XFER_DONE=1.
  - Read: RD_DATA=rd_shift and DATA_RDY=1 in the same cycle.
  - BUSY=0 on exit to IDLE.
- Latency: accepted start to XFER_DONE = 1 + 32*CLK_DIV CLK cycles.
- Back-to-back: a MDIO_START in the cycle after DONE is accepted; MDC remains 0 for at least 1 CLK between frames.
- Width rules: bit_cnt is 5 bits and does not wrap inside a frame. The divider counter width is $clog2(CLK_DIV/2), minimum 1.

Decomposition:
- Package mdio_pkg:
  - OP_WRITE=2'b01, OP_READ=2'b10, ST_CODE=2'b01.
  - FRAME_W=32, DATA_W=16, TA_IDX=17.
  - State encoding IDLE/DRIVE/RECV/DONE.
- Sub-module mdc_clkgen (param CLK_DIV; ports en, mdc, rise_pulse, fall_pulse). The main FSM consumes only the rise/fall pulses.

Test Plan:
- Write, CLK_DIV=4, T_DATA=32'h5096ABCD -> MDIO_OUT over 32 MDC rises = 0101_00001_00101_10_1010101111001101; MDIO_OE=1 for all 32; XFER_DONE at CLK 129 after start; DATA_RDY stays 0; peripheral model shows WR_STB with ADDR=5'd5, WR_DATA=16'hABCD.
- Read, T_DATA=32'h60940000, PHY model returns 16'h1234 -> MDIO_OE falls at the bit-17 MDC fall; RD_DATA=16'h1234 with a DATA_RDY pulse in the same cycle as XFER_DONE.
- Invalid OP, T_DATA=32'h70000000 (OP=11) and 32'h40000000 (OP=00) -> OP_ERR pulse each time; BUSY, MDC and MDIO_OE remain 0.
- MDIO_START re-asserted at CLK 10 and CLK 60 of a write -> ignored; frame bits unchanged; exactly one XFER_DONE.
- RESET=0 at bit index 20 of a read -> all outputs 0 asynchronously; after release, a new write completes normally and RD_DATA=0.
- CLK_DIV=2 and CLK_DIV=8 back-to-back write then read -> MDC period 2/8 CLK; second frame starts the cycle after DONE; latencies 65 and 257 CLK.
